// File: rtl/seed_sweep_ctrl.sv
// Seed sweep sequencer: walks a seed ROM, runs the network datapath once per
// seed, and reports the final state, round count and end cause for each run.
module seed_sweep_ctrl #(
  parameter int RULES        = 16,
  parameter int LOG_RULES    = 4,
  parameter int NUM_SEEDS    = 8,
  parameter int SEED_AW      = 3,
  parameter int ROUND_NUMBER = 100,
  parameter int EARLY_STOP   = 1,
  parameter int WATCHDOG     = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic [LOG_RULES-1:0] inhibitor_idx,
  output logic [SEED_AW-1:0]   seed_addr,
  input  logic [63:0]          seed_data,
  output logic                 dp_rst_n,
  output logic                 dp_ld_inhibitor,
  output logic [LOG_RULES-1:0] dp_sel_inhibitor,
  output logic [63:0]          dp_seed,
  output logic                 dp_start,
  input  logic [9:0]           dp_round_number,
  input  logic                 dp_steady_state,
  input  logic [RULES-1:0]     dp_network_state,
  output logic                 busy,
  output logic                 res_valid,
  output logic [SEED_AW-1:0]   res_seed_idx,
  output logic [RULES-1:0]     res_state,
  output logic [9:0]           res_rounds,
  output logic                 res_steady,
  output logic                 res_timeout,
  output logic [SEED_AW:0]     ss_count,
  output logic                 done,
  output logic [3:0]           dbg_state
);

  localparam int WD_W = $clog2(WATCHDOG) + 1;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_RST_A, S_RST_B, S_LOAD,
    S_GAP, S_START, S_RUN, S_REPORT, S_DONE
  } state_t;

  state_t              state, state_nx;
  logic [SEED_AW-1:0]  idx;
  logic [WD_W-1:0]     wd;
  logic                end_rounds, end_steady, end_wd, run_end, last_seed;

  assign end_rounds = (dp_round_number >= 10'(ROUND_NUMBER));
  assign end_steady = (EARLY_STOP != 0) && dp_steady_state;
  assign end_wd     = (wd == WD_W'(WATCHDOG - 1));
  assign run_end    = end_rounds || end_steady || end_wd;
  assign last_seed  = (idx == SEED_AW'(NUM_SEEDS - 1));

  assign seed_addr = idx;
  assign dbg_state = state;

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (go) state_nx = S_FETCH;
      S_FETCH:  state_nx = S_RST_A;
      S_RST_A:  state_nx = S_RST_B;
      S_RST_B:  state_nx = S_LOAD;
      S_LOAD:   state_nx = S_GAP;
      S_GAP:    state_nx = S_START;
      S_START:  state_nx = S_RUN;
      S_RUN:    if (run_end) state_nx = S_REPORT;
      S_REPORT: state_nx = last_seed ? S_DONE : S_FETCH;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Strobes are pure state decodes; the datapath stays in reset outside a run.
  always_comb begin
    busy            = 1'b1;
    dp_rst_n        = 1'b1;
    dp_ld_inhibitor = 1'b0;
    dp_start        = 1'b0;
    res_valid       = 1'b0;
    done            = 1'b0;
    unique case (state)
      S_IDLE:   begin busy = 1'b0; dp_rst_n = 1'b0; end
      S_FETCH,
      S_RST_A,
      S_RST_B:  dp_rst_n = 1'b0;
      S_LOAD:   dp_ld_inhibitor = 1'b1;
      S_START:  dp_start = 1'b1;
      S_REPORT: res_valid = 1'b1;
      S_DONE:   begin done = 1'b1; dp_rst_n = 1'b0; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      idx              <= '0;
      wd               <= '0;
      dp_sel_inhibitor <= '1;
      dp_seed          <= '0;
      res_seed_idx     <= '0;
      res_state        <= '0;
      res_rounds       <= '0;
      res_steady       <= 1'b0;
      res_timeout      <= 1'b0;
      ss_count         <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        S_IDLE: begin
          if (go) begin
            idx              <= '0;
            ss_count         <= '0;
            wd               <= '0;
            dp_sel_inhibitor <= inhibitor_idx;
          end
        end
        S_RST_A: dp_seed <= seed_data;
        S_START: wd <= '0;
        S_RUN: begin
          wd <= wd + 1'b1;
          if (run_end) begin
            res_seed_idx <= idx;
            res_state    <= dp_network_state;
            res_rounds   <= dp_round_number;
            res_steady   <= dp_steady_state;
            // Round/steady completion wins over a coincident watchdog expiry.
            res_timeout  <= end_wd && !end_rounds && !end_steady;
          end
        end
        S_REPORT: begin
          if (res_steady) ss_count <= ss_count + 1'b1;
          if (!last_seed) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
